hazard_ctrl: RTL and testbench

- Central interlock and forwarding controller for the 5-stage pipeline (IF, DE, EXE, MEM, WB).
- Keeps a shadow scoreboard of destination registers for the instructions in EXE, MEM and WB.
- Compares the decoding instruction's source registers against that scoreboard and produces the decode stall, the EXE bubble insert and the per-operand forwarding selects.
- Replaces the ad-hoc load and branch stall logic inside decode; counts stall cycles for performance debug.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Interlock and forwarding controller for the 5-stage pipeline
//            (IF, DE, EXE, MEM, WB). Tracks destination registers of the
//            instructions in EXE/MEM/WB in a shadow scoreboard, and from it
//            derives the decode stall, the EXE bubble and per-operand
//            forwarding selects. Counts hazard stall cycles.
// Ports    : clk, resetn (sync, active-low)
//            de_*_i       decode-stage instruction description
//            mem_stall_i  whole-pipeline freeze from data RAM
//            stall_o      hold PC and IF/DE registers
//            bubble_o     force DE->EXE registers to a NOP
//            fwd_rs_sel_o / fwd_rt_sel_o  0 regfile, 1 EXE, 2 MEM, 3 WB
//            stall_cnt_o  hazard stall cycle counter (wraps)
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             de_valid_i,
    input  logic [RA_W-1:0]  de_rs_i,
    input  logic [RA_W-1:0]  de_rt_i,
    input  logic             de_use_rs_i,
    input  logic             de_use_rt_i,
    input  logic             de_wen_i,
    input  logic [RA_W-1:0]  de_dest_i,
    input  logic             de_is_load_i,
    input  logic             de_is_br_i,
    input  logic             mem_stall_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [1:0]       fwd_rs_sel_o,
    output logic [1:0]       fwd_rt_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic            v;
        logic            wen;
        logic [RA_W-1:0] dest;
        logic            ld;
    } sb_t;

    localparam sb_t        c_SB_EMPTY = '0;
    localparam logic [1:0] c_SEL_RF   = 2'd0;
    localparam logic [1:0] c_SEL_EXE  = 2'd1;
    localparam logic [1:0] c_SEL_MEM  = 2'd2;
    localparam logic [1:0] c_SEL_WB   = 2'd3;

    sb_t              ex_q,  ex_d;
    sb_t              mem_q, mem_d;
    sb_t              wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // $0 is hardwired to zero, so it never produces a dependency.
    function automatic logic f_match(input sb_t e, input logic used,
                                     input logic [RA_W-1:0] src);
        return used & e.v & e.wen & (e.dest == src) & (src != '0);
    endfunction

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
    logic w_load_use, w_branch, w_hazard;

    always_comb begin
        w_ex_rs  = f_match(ex_q,  de_use_rs_i, de_rs_i);
        w_ex_rt  = f_match(ex_q,  de_use_rt_i, de_rt_i);
        w_mem_rs = f_match(mem_q, de_use_rs_i, de_rs_i);
        w_mem_rt = f_match(mem_q, de_use_rt_i, de_rt_i);
        w_wb_rs  = f_match(wb_q,  de_use_rs_i, de_rs_i);
        w_wb_rt  = f_match(wb_q,  de_use_rt_i, de_rt_i);

        w_load_use = ex_q.ld & (w_ex_rs | w_ex_rt);
        // Branches resolve in DE, so an ALU result still in EXE is too late,
        // and load data in MEM is not ready until the end of MEM.
        w_branch   = de_is_br_i & ((w_ex_rs | w_ex_rt) |
                                   (mem_q.ld & (w_mem_rs | w_mem_rt)));
        w_hazard   = de_valid_i & (w_load_use | w_branch);
    end

    assign stall_o  = w_hazard | mem_stall_i;
    assign bubble_o = w_hazard & ~mem_stall_i;

    // First match wins; the load-in-EXE and load-in-MEM-for-branch cases
    // resolve to the regfile but are always covered by a hazard stall.
    always_comb begin
        fwd_rs_sel_o = c_SEL_RF;
        if (w_ex_rs)
            fwd_rs_sel_o = ex_q.ld ? c_SEL_RF : c_SEL_EXE;
        else if (w_mem_rs)
            fwd_rs_sel_o = (mem_q.ld & de_is_br_i) ? c_SEL_RF : c_SEL_MEM;
        else if (w_wb_rs)
            fwd_rs_sel_o = c_SEL_WB;

        fwd_rt_sel_o = c_SEL_RF;
        if (w_ex_rt)
            fwd_rt_sel_o = ex_q.ld ? c_SEL_RF : c_SEL_EXE;
        else if (w_mem_rt)
            fwd_rt_sel_o = (mem_q.ld & de_is_br_i) ? c_SEL_RF : c_SEL_MEM;
        else if (w_wb_rt)
            fwd_rt_sel_o = c_SEL_WB;
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_stall_i) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (w_hazard) begin
                ex_d        = c_SB_EMPTY;
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ex_d.v    = de_valid_i;
                ex_d.wen  = de_wen_i;
                ex_d.dest = de_dest_i;
                ex_d.ld   = de_is_load_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_q        <= c_SB_EMPTY;
            mem_q       <= c_SB_EMPTY;
            wb_q        <= c_SB_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        de_valid, de_use_rs, de_use_rt, de_wen, de_is_load, de_is_br;
    logic [4:0]  de_rs, de_rt, de_dest;
    logic        mem_stall;
    logic        stall, bubble;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .de_valid_i   (de_valid),
        .de_rs_i      (de_rs),
        .de_rt_i      (de_rt),
        .de_use_rs_i  (de_use_rs),
        .de_use_rt_i  (de_use_rt),
        .de_wen_i     (de_wen),
        .de_dest_i    (de_dest),
        .de_is_load_i (de_is_load),
        .de_is_br_i   (de_is_br),
        .mem_stall_i  (mem_stall),
        .stall_o      (stall),
        .bubble_o     (bubble),
        .fwd_rs_sel_o (fwd_rs_sel),
        .fwd_rt_sel_o (fwd_rt_sel),
        .stall_cnt_o  (stall_cnt)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wen,
                         input logic [4:0] dest, input logic ld, input logic br);
        de_valid = v;  de_rs = rs;    de_rt = rt;
        de_use_rs = urs; de_use_rt = urt; de_wen = wen;
        de_dest = dest; de_is_load = ld; de_is_br = br;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; mem_stall = 1'b0; nop();
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; mem_stall = 1'b1; nop();
        tick(); settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_memstall got=%b exp=1", stall); end
        total++; if (bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
        mem_stall = 1'b0;
        tick(); settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        resetn = 1'b1;
    endtask

    task automatic test_alu_alu();
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);           // ADDU $3,$1,$2
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu1_stall got=%b exp=0", stall); end
        tick();
        drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0, 0);           // ADDU $4,$3,$3
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu2_stall got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd1 || fwd_rt_sel !== 2'd1) begin bad++; $display("FAIL alu2_fwd got=%0d/%0d exp=1/1", fwd_rs_sel, fwd_rt_sel); end
        tick(); nop(); settle();
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL alu_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);           // LW $5
        tick();
        drive(1, 5'd5, 5'd0, 1, 1, 1, 5'd6, 0, 0);           // ADDU $6,$5,$0
        settle();
        total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b%b exp=11", stall, bubble); end
        tick(); settle();
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL lu_release got=%b%b exp=00", stall, bubble); end
        total++; if (fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL lu_fwd got=%0d/%0d exp=2/0", fwd_rs_sel, fwd_rt_sel); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        tick(); nop();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 1, 0);           // LW $7
        tick();
        drive(1, 5'd7, 5'd0, 1, 1, 0, 5'd0, 0, 1);           // BEQ $7,$0
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ldbr_stall1 got=%b exp=1", stall); end
        tick(); settle();
        total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL ldbr_stall2 got=%b%b exp=11", stall, bubble); end
        tick(); settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ldbr_release got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd3) begin bad++; $display("FAIL ldbr_fwd got=%0d exp=3", fwd_rs_sel); end
        total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL ldbr_cnt got=%0d exp=2", stall_cnt); end
        tick();
        drive(1, 5'd2, 5'd3, 1, 1, 1, 5'd8, 0, 0);           // ADDU $8
        tick();
        drive(1, 5'd8, 5'd1, 1, 1, 0, 5'd0, 0, 1);           // BNE $8,$1
        settle();
        total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL alubr_stall got=%b%b exp=11", stall, bubble); end
        tick(); settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alubr_release got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL alubr_fwd got=%0d/%0d exp=2/0", fwd_rs_sel, fwd_rt_sel); end
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL alubr_cnt got=%0d exp=3", stall_cnt); end
        tick(); nop();
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0);           // ADDU $0
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd9, 0, 0);           // ADDU $9,$0,$0
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_alu_stall got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL zero_alu_fwd got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
        tick();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1, 0);           // LW $0
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 1);           // BEQ $0,$0
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_ld_stall got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL zero_ld_fwd got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL zero_cnt got=%0d exp=0", stall_cnt); end
        tick(); nop();
    endtask

    task automatic test_mem_stall();
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);           // LW $5
        tick();
        drive(1, 5'd5, 5'd0, 1, 0, 1, 5'd6, 0, 0);           // use of $5
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (stall !== 1'b1 || bubble !== 1'b0) begin bad++; $display("FAIL ms_frozen%0d got=%b%b exp=10", i, stall, bubble); end
            tick();
        end
        mem_stall = 1'b0;
        settle();
        total++; if (stall !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL ms_hazard got=%b%b exp=11", stall, bubble); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL ms_cnt_frozen got=%0d exp=0", stall_cnt); end
        tick(); settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ms_release got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd2) begin bad++; $display("FAIL ms_fwd got=%0d exp=2", fwd_rs_sel); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL ms_cnt got=%0d exp=1", stall_cnt); end
        tick(); nop();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);           // LW $5
        tick();
        drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 0);           // use of $5
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre got=%b exp=1", stall); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_stall got=%b exp=0", stall); end
        total++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin bad++; $display("FAIL rms_fwd got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt); end
        tick(); nop();
    endtask

    task automatic test_invalid_de();
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0);           // LW $5
        tick();
        drive(0, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 1);           // not valid
        settle();
        total++; if (stall !== 1'b0 || bubble !== 1'b0) begin bad++; $display("FAIL inv_stall got=%b%b exp=00", stall, bubble); end
        tick();
        drive(1, 5'd6, 5'd0, 1, 0, 1, 5'd7, 0, 1);           // JR $6: EXE is the invalid slot
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL inv_bubble_entry got=%b exp=0", stall); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL inv_cnt got=%0d exp=0", stall_cnt); end
        tick(); nop();
    endtask

    initial begin
        resetn = 1'b0; mem_stall = 1'b0; nop();
        test_reset();
        test_alu_alu();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_mem_stall();
        test_reset_mid_stall();
        test_invalid_de();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
